// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Single-port 8-bit memory slave. It accepts one read or write request
//   while idle, inserts WAIT_CYCLES wait states, and performs the access in
//   a one-cycle ACCESS state. Ready (and Err) pulse for the cycle after
//   ACCESS, and read data is valid on DataOut in that same cycle.
//
//   Optional feature: define MEM_RANGE_CHECK_EN to flag latched addresses
//   >= DEPTH. Such an access is suppressed and Err pulses with Ready. When
//   the macro is undefined, Err is tied low and addresses index modulo DEPTH.
//
// Parameters
//   WAIT_CYCLES  wait states per access (0..15)
//   DEPTH        implemented 8-bit words (1..256)
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   MemRead   in   read request level (sampled only in IDLE)
//   MemWrite  in   write request level (sampled only in IDLE, wins over read)
//   Addr      in   word address, captured at acceptance
//   DataIn    in   write data, captured at acceptance
//   DataOut   out  registered read data, held until the next read completes
//   Ready     out  one-cycle completion pulse
//   Busy      out  high whenever the FSM is not in IDLE
//   Err       out  one-cycle out-of-range pulse, coincident with Ready
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DEPTH       = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       MemWrite,
  input  logic [7:0] Addr,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
  output logic       Ready,
  output logic       Busy,
  output logic       Err
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [8:0]  DEPTH_9 = 9'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  logic [7:0]       addr_p0;
  logic [7:0]       din_p0;
  logic             wr_p0;

  logic [7:0]       dout_p1;
  logic             vld_p1;

  logic [7:0]       mem [DEPTH];

  // Word index: the address reduced modulo DEPTH. With range checking on,
  // out-of-range accesses are suppressed, so the reduced index is only a
  // safe in-bounds value for them.
  function automatic logic [IDX_W-1:0] mem_index(input logic [7:0] a);
    logic [8:0] m;
    m = {1'b0, a} % DEPTH_9;
    return m[IDX_W-1:0];
  endfunction

  assign accept = (state == IDLE) && (MemRead || MemWrite);
  assign idx    = mem_index(addr_p0);

`ifdef MEM_RANGE_CHECK_EN
  assign in_range = ({1'b0, addr_p0} < DEPTH_9);
`else
  assign in_range = 1'b1;
`endif

  // ---- stage p0: request capture at acceptance ----
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_p0 <= Addr;
      din_p0  <= DataIn;
      wr_p0   <= MemWrite;
    end
  end

  // ---- stage p1: memory array write at the edge leaving ACCESS ----
  // Not reset: contents survive reset. A reset during a pending access
  // forces IDLE asynchronously, so the gated write never happens.
  always_ff @(posedge clock) begin
    if ((state == ACCESS) && wr_p0 && in_range) begin
      mem[idx] <= din_p0;
    end
  end

  // ---- stage p1: control state, wait counter, registered outputs ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      vld_p1  <= 1'b0;
      dout_p1 <= 8'h00;
    end else begin
      state  <= state_nxt;
      vld_p1 <= (state == ACCESS);
      if (accept) begin
        cnt <= WAIT_LD;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if ((state == ACCESS) && !wr_p0 && in_range) begin
        dout_p1 <= mem[idx];
      end
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic err_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= (state == ACCESS) && !in_range;
    end
  end

  assign Err = err_p1;
`else
  assign Err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          state_nxt = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign DataOut = dout_p1;
  assign Ready   = vld_p1;
  assign Busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Scoreboard bench for mem_responder. The main instance runs with
//   WAIT_CYCLES = 2; a second instance with WAIT_CYCLES = 0 exercises the
//   continuous-read pattern. Stimulus pushes expected responses into a
//   queue; a negedge monitor pops one per Ready pulse and checks latency,
//   DataOut and Err.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  localparam int MAIN_WAIT = 2;
`ifdef MEM_RANGE_CHECK_EN
  localparam int MAIN_DEPTH = 128;
`else
  localparam int MAIN_DEPTH = 256;
`endif
  localparam logic [7:0] TOP_A = 8'(MAIN_DEPTH - 1);

  logic       clock = 1'b0;
  logic       rst_n;
  logic       MemRead, MemWrite;
  logic [7:0] Addr, DataIn;
  logic [7:0] DataOut;
  logic       Ready, Busy, Err;

  logic       zrd, zwr;
  logic [7:0] zaddr, zdin;
  logic [7:0] zdout;
  logic       zready, zbusy, zerr;

  always #5 clock = ~clock;

  mem_responder #(.WAIT_CYCLES(MAIN_WAIT), .DEPTH(MAIN_DEPTH)) u_dut (
    .clock   (clock),
    .reset   (rst_n),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Ready   (Ready),
    .Busy    (Busy),
    .Err     (Err)
  );

  mem_responder #(.WAIT_CYCLES(0), .DEPTH(256)) u_dut_z (
    .clock   (clock),
    .reset   (rst_n),
    .MemRead (zrd),
    .MemWrite(zwr),
    .Addr    (zaddr),
    .DataIn  (zdin),
    .DataOut (zdout),
    .Ready   (zready),
    .Busy    (zbusy),
    .Err     (zerr)
  );

  typedef struct {
    logic       is_wr;
    logic [7:0] data;
    logic       err;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         pcnt   = 0;
  logic [7:0] model_dout;

  function void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endfunction

  always @(posedge clock) pcnt <= pcnt + 1;

  // Monitor: one expectation consumed per Ready pulse.
  always @(negedge clock) begin
    if (rst_n && Ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: actual=1 required=0 at t=%0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", pcnt - mon_e.acc, MAIN_WAIT + 1);
        chk(mon_e.is_wr ? "dataout_after_write" : "read_data", int'(DataOut), int'(mon_e.data));
        chk("err", int'(Err), int'(mon_e.err));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!Ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!Ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: actual=0 required=1 at t=%0t", $time);
    end
  endtask

  // Called at a negedge; the request is accepted at the next posedge.
  task automatic issue(input logic wr, input logic rd, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] rexp,
                       input logic eerr, input logic inject);
    exp_t e;
    MemWrite = wr;
    MemRead  = rd;
    Addr     = a;
    DataIn   = d;
    e.is_wr  = wr;
    e.err    = eerr;
    e.acc    = pcnt + 1;
    if (wr || eerr) begin
      e.data = model_dout;
    end else begin
      e.data     = rexp;
      model_dout = rexp;
    end
    sb.push_back(e);
    @(negedge clock);
    MemRead  = 1'b0;
    MemWrite = inject;
    if (inject) begin
      Addr   = 8'h20;
      DataIn = 8'hEE;
    end
    @(negedge clock);
    MemWrite = 1'b0;
    wait_ready();
  endtask

  task automatic do_req(input logic wr, input logic rd, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] rexp, input logic eerr);
    @(negedge clock);
    issue(wr, rd, a, d, rexp, eerr, 1'b0);
  endtask

  task automatic back_to_back(input logic [7:0] a, input logic [7:0] rexp);
    exp_t e;
    @(negedge clock);
    MemRead  = 1'b1;
    Addr     = a;
    e.is_wr  = 1'b0;
    e.err    = 1'b0;
    e.data   = rexp;
    e.acc    = pcnt + 1;
    sb.push_back(e);
    e.acc    = pcnt + 1 + MAIN_WAIT + 2;
    sb.push_back(e);
    model_dout = rexp;
    @(negedge clock);
    wait_ready();
    @(negedge clock);
    MemRead = 1'b0;
    wait_ready();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; Addr = 8'h00; DataIn = 8'h00;
    zrd = 1'b0; zwr = 1'b0; zaddr = 8'h00; zdin = 8'h00;
    model_dout = 8'h00;

    // Reset values.
    repeat (2) @(negedge clock);
    chk("rst_dataout", int'(DataOut), 0);
    chk("rst_ready", int'(Ready), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_err", int'(Err), 0);
    chk("rst_z_busy", int'(zbusy), 0);
    rst_n = 1'b1;

    // Write then read with two wait states.
    do_req(1'b1, 1'b0, 8'h05, 8'h3C, 8'h00, 1'b0);
    do_req(1'b0, 1'b1, 8'h05, 8'h00, 8'h3C, 1'b0);
    do_req(1'b1, 1'b0, TOP_A, 8'hC3, 8'h00, 1'b0);
    do_req(1'b0, 1'b1, TOP_A, 8'h00, 8'hC3, 1'b0);
    do_req(1'b1, 1'b0, 8'h00, 8'h12, 8'h00, 1'b0);

    // Collision: both request lines high -> write only.
    do_req(1'b1, 1'b1, 8'h07, 8'h99, 8'h00, 1'b0);
    do_req(1'b0, 1'b1, 8'h07, 8'h00, 8'h99, 1'b0);

    // Write pulse while busy is ignored.
    do_req(1'b1, 1'b0, 8'h20, 8'h11, 8'h00, 1'b0);
    do_req(1'b1, 1'b0, 8'h30, 8'h77, 8'h00, 1'b0);
    @(negedge clock);
    issue(1'b0, 1'b1, 8'h30, 8'h00, 8'h77, 1'b0, 1'b1);
    do_req(1'b0, 1'b1, 8'h20, 8'h00, 8'h11, 1'b0);

    // Read held through the Ready cycle is accepted again at that edge.
    back_to_back(8'h05, 8'h3C);

`ifdef MEM_RANGE_CHECK_EN
    do_req(1'b1, 1'b0, 8'h80, 8'hAB, 8'h00, 1'b1);
    do_req(1'b0, 1'b1, 8'h80, 8'h00, 8'h00, 1'b1);
    do_req(1'b0, 1'b1, 8'h00, 8'h00, 8'h12, 1'b0);
`endif

    // Reset in the middle of WAIT aborts the write.
    do_req(1'b1, 1'b0, 8'h10, 8'h5A, 8'h00, 1'b0);
    @(negedge clock);
    MemWrite = 1'b1; Addr = 8'h10; DataIn = 8'hA5;
    @(negedge clock);
    MemWrite = 1'b0;
    chk("abort_busy_before_reset", int'(Busy), 1);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("inrst_ready", int'(Ready), 0);
      chk("inrst_busy", int'(Busy), 0);
      chk("inrst_dataout", int'(DataOut), 0);
      chk("inrst_err", int'(Err), 0);
    end
    model_dout = 8'h00;
    rst_n = 1'b1;
    issue(1'b0, 1'b1, 8'h10, 8'h00, 8'h5A, 1'b0, 1'b0);

    // Zero-wait instance: continuous read gives Ready every 2nd cycle.
    @(negedge clock);
    zwr = 1'b1; zaddr = 8'h03; zdin = 8'h42;
    @(negedge clock);
    chk("z_busy_write", int'(zbusy), 1);
    zwr = 1'b0;
    @(negedge clock);
    chk("z_ready_write", int'(zready), 1);
    chk("z_dout_after_write", int'(zdout), 0);
    zrd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("z_busy_%0d", i), int'(zbusy), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("z_ready_%0d", i), int'(zready), (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 1) chk($sformatf("z_dout_%0d", i), int'(zdout), 8'h42);
      chk($sformatf("z_err_%0d", i), int'(zerr), 0);
    end
    zrd = 1'b0;

    repeat (4) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_busy", int'(Busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
